// File: rtl/apb_intc_vec.sv
// APB vectored interrupt controller: per-source synchronisers, level/edge
// detection with polarity, fixed-priority claim/EOI and a registered CPU request.
module apb_intc_vec #(
    parameter int          NUM_SRC     = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EDGE_RST    = 32'h0
) (
    input  logic               apb_pclk,
    input  logic               apb_prstn,
    input  logic               apb_psel,
    input  logic               apb_penable,
    input  logic               apb_pwrite,
    input  logic [19:0]        apb_paddr,
    input  logic [31:0]        apb_pwdata,
    output logic [31:0]        apb_prdata,
    input  logic [NUM_SRC-1:0] int_src,
    output logic               int_o,
    output logic [5:0]         int_id
);

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] syncDly_q;
    logic [NUM_SRC-1:0] intEn_q, intEdge_q, intPol_q;
    logic [NUM_SRC-1:0] latch_q, latch_d;
    logic [NUM_SRC-1:0] insvc_q, insvc_d;
    logic               intO_q;
    logic [5:0]         intId_q;

    logic               wrEn, rdEn;
    logic [3:0]         regSel;
    logic [NUM_SRC-1:0] wdat, syncLast, active, edgeEvt, pend, claimable;
    logic [NUM_SRC-1:0] winOh, clrMask, setMask, claimMask, eoiMask;
    logic               winValid, claimHit;
    logic [4:0]         winId;
    logic               unusedBits;

    assign wrEn       = apb_psel & apb_penable & apb_pwrite;
    assign rdEn       = apb_psel & apb_penable & ~apb_pwrite;
    assign regSel     = apb_paddr[5:2];
    assign wdat       = apb_pwdata[NUM_SRC-1:0];
    assign unusedBits = ^{apb_paddr[19:6], apb_paddr[1:0], apb_pwdata};

    assign syncLast  = sync_q[SYNC_STAGES-1];
    assign active    = ~(syncLast ^ intPol_q);
    assign edgeEvt   = intEdge_q & active & (syncLast ^ syncDly_q);
    assign pend      = (intEdge_q & latch_q) | (~intEdge_q & active);
    assign claimable = pend & intEn_q & ~insvc_q;

    // Scan from the top so the lowest claimable index wins.
    always_comb begin
        winValid = 1'b0;
        winId    = '0;
        winOh    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (claimable[i]) begin
                winValid = 1'b1;
                winId    = 5'(i);
                winOh    = '0;
                winOh[i] = 1'b1;
            end
        end
    end

    assign claimHit  = rdEn && (regSel == 4'h6) && winValid;
    assign claimMask = claimHit ? winOh : '0;
    assign clrMask   = (wrEn && regSel == 4'h4) ? wdat : '0;
    assign setMask   = (wrEn && regSel == 4'h5) ? (wdat & intEdge_q) : '0;

    always_comb begin
        eoiMask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eoiMask[i] = wrEn && (regSel == 4'h7) && (apb_pwdata[4:0] == 5'(i));
        end
    end

    // Edge events are OR'd in after the clears so a coincident event survives.
    assign latch_d = (latch_q & ~clrMask & ~(claimMask & intEdge_q)) | setMask | edgeEvt;
    assign insvc_d = (insvc_q | claimMask) & ~clrMask & ~eoiMask;

    always_comb begin
        apb_prdata = '0;
        case (regSel)
            4'h0: apb_prdata = 32'(intEn_q);
            4'h1: apb_prdata = 32'(intEdge_q);
            4'h2: apb_prdata = 32'(intPol_q);
            4'h3: apb_prdata = 32'(pend);
            4'h6: apb_prdata = winValid ? {1'b1, 26'b0, winId} : 32'h0;
            4'h8: apb_prdata = 32'(insvc_q);
            default: apb_prdata = '0;
        endcase
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            syncDly_q <= '0;
            intEn_q   <= '0;
            intEdge_q <= EDGE_RST[NUM_SRC-1:0];
            intPol_q  <= '1;
            latch_q   <= '0;
            insvc_q   <= '0;
            intO_q    <= 1'b0;
            intId_q   <= '0;
        end else begin
            sync_q[0] <= int_src;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            syncDly_q <= syncLast;
            if (wrEn && regSel == 4'h0) intEn_q   <= wdat;
            if (wrEn && regSel == 4'h1) intEdge_q <= wdat;
            if (wrEn && regSel == 4'h2) intPol_q  <= wdat;
            latch_q <= latch_d;
            insvc_q <= insvc_d;
            intO_q  <= winValid;
            intId_q <= {winValid, winId};
        end
    end

    assign int_o  = intO_q;
    assign int_id = intId_q;

endmodule

// File: tb/tb_apb_intc_vec.sv
// Scoreboard bench for apb_intc_vec: directed APB traffic pushes expected values,
// independent monitors pop and compare read data and interrupt outputs.
module tb_apb_intc_vec;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } expT;

    logic        apb_pclk = 1'b0;
    logic        apb_prstn;
    logic        apb_psel, apb_penable, apb_pwrite;
    logic [19:0] apb_paddr;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic [15:0] int_src;
    logic        int_o;
    logic [5:0]  int_id;

    expT  rdQ[$];
    expT  obsQ[$];
    event obsEv;
    int   checks = 0;
    int   errors = 0;

    apb_intc_vec #(.NUM_SRC(16), .SYNC_STAGES(2), .EDGE_RST(32'h0)) dut (
        .apb_pclk   (apb_pclk),
        .apb_prstn  (apb_prstn),
        .apb_psel   (apb_psel),
        .apb_penable(apb_penable),
        .apb_pwrite (apb_pwrite),
        .apb_paddr  (apb_paddr),
        .apb_pwdata (apb_pwdata),
        .apb_prdata (apb_prdata),
        .int_src    (int_src),
        .int_o      (int_o),
        .int_id     (int_id)
    );

    always #5 apb_pclk = ~apb_pclk;

    // Read-data monitor: every read access phase consumes one expected entry.
    always @(negedge apb_pclk) begin
        expT e;
        if (apb_psel && apb_penable && !apb_pwrite) begin
            checks++;
            if (rdQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_read: got 0x%08h, no expected value queued", apb_prdata);
            end else begin
                e = rdQ.pop_front();
                if (apb_prdata !== e.exp) begin
                    errors++;
                    $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, apb_prdata, e.exp);
                end
            end
        end
    end

    // Output monitor: kind 0 is int_o, kind 1 is int_id.
    always begin
        expT         e;
        logic [31:0] act;
        @(obsEv);
        while (obsQ.size() > 0) begin
            e   = obsQ.pop_front();
            act = (e.kind == 0) ? {31'b0, int_o} : {26'b0, int_id};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge apb_pclk);
        #1;
    endtask

    // Entered and left one time unit after a rising edge; commits two edges later.
    task automatic applyStimulus(input logic wr, input logic [19:0] addr,
                                 input logic [31:0] data, input string name);
        apb_psel    = 1'b1;
        apb_penable = 1'b0;
        apb_pwrite  = wr;
        apb_paddr   = addr;
        apb_pwdata  = wr ? data : 32'h0;
        if (!wr) rdQ.push_back('{name, 0, data});
        tick(1);
        apb_penable = 1'b1;
        tick(1);
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int kind, input logic [31:0] exp);
        obsQ.push_back('{name, kind, exp});
        ->obsEv;
    endtask

    initial begin
        apb_prstn = 1'b0; apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
        apb_paddr = '0; apb_pwdata = '0; int_src = '0;
        tick(3);
        checkOutput("rst_int_o", 0, 32'h0);
        checkOutput("rst_int_id", 1, 32'h0);
        apb_prstn = 1'b1;
        tick(2);

        applyStimulus(1'b0, 20'h00, 32'h0000_0000, "rst_en");
        applyStimulus(1'b0, 20'h04, 32'h0000_0000, "rst_edge");
        applyStimulus(1'b0, 20'h08, 32'h0000_FFFF, "rst_pol");
        applyStimulus(1'b0, 20'h0C, 32'h0000_0000, "rst_pend");
        applyStimulus(1'b0, 20'h20, 32'h0000_0000, "rst_insvc");
        applyStimulus(1'b0, 20'h24, 32'h0000_0000, "unmapped");
        applyStimulus(1'b1, 20'h00, 32'hFFFF_FFFF, "en_all");
        applyStimulus(1'b0, 20'h00, 32'h0000_FFFF, "en_masked");
        applyStimulus(1'b0, 20'h10, 32'h0000_0000, "clr_reads_zero");

        // Level source 0: three-cycle latency, claim, EOI re-raise.
        applyStimulus(1'b1, 20'h00, 32'h1, "en_1");
        int_src = 16'h0001;
        tick(2);
        checkOutput("lvl_int_o_early", 0, 32'h0);
        tick(1);
        checkOutput("lvl_int_o_3cyc", 0, 32'h1);
        checkOutput("lvl_int_id", 1, 32'h20);
        applyStimulus(1'b0, 20'h18, 32'h8000_0000, "claim_src0");
        checkOutput("claim_int_o_hold", 0, 32'h1);
        tick(1);
        checkOutput("claim_int_o_fall", 0, 32'h0);
        applyStimulus(1'b0, 20'h20, 32'h0000_0001, "insvc_src0");
        applyStimulus(1'b1, 20'h1C, 32'h0, "eoi_0");
        tick(1);
        checkOutput("eoi_reassert", 0, 32'h1);
        int_src = 16'h0000;
        tick(4);
        checkOutput("lvl_drop_int_o", 0, 32'h0);

        // Priority between sources 3 and 7.
        applyStimulus(1'b1, 20'h00, 32'h88, "en_88");
        int_src = 16'h0088;
        tick(4);
        checkOutput("prio_int_o", 0, 32'h1);
        checkOutput("prio_int_id", 1, 32'h23);
        applyStimulus(1'b0, 20'h18, 32'h8000_0003, "claim_src3");
        applyStimulus(1'b0, 20'h18, 32'h8000_0007, "claim_src7");
        applyStimulus(1'b0, 20'h18, 32'h0000_0000, "claim_none");
        applyStimulus(1'b0, 20'h20, 32'h0000_0088, "insvc_88");
        checkOutput("prio_int_o_off", 0, 32'h0);
        applyStimulus(1'b1, 20'h1C, 32'h3, "eoi_3");
        applyStimulus(1'b0, 20'h20, 32'h0000_0080, "insvc_80");
        applyStimulus(1'b1, 20'h1C, 32'h7, "eoi_7");
        applyStimulus(1'b0, 20'h20, 32'h0000_0000, "insvc_0");
        int_src = 16'h0000;
        applyStimulus(1'b1, 20'h00, 32'h0, "en_0");

        // Active-low edge source 2.
        int_src = 16'hFFFF;
        tick(4);
        applyStimulus(1'b1, 20'h04, 32'h4, "edge_4");
        applyStimulus(1'b1, 20'h08, 32'h0, "pol_0");
        tick(2);
        applyStimulus(1'b0, 20'h0C, 32'h0000_0000, "pend_idle");
        int_src = 16'hFFFB;
        tick(1);
        int_src = 16'hFFFF;
        tick(5);
        applyStimulus(1'b0, 20'h0C, 32'h0000_0004, "pend_edge");
        tick(3);
        applyStimulus(1'b0, 20'h0C, 32'h0000_0004, "pend_held");
        checkOutput("edge_disabled_int_o", 0, 32'h0);
        applyStimulus(1'b1, 20'h10, 32'h4, "clr_4");
        applyStimulus(1'b0, 20'h0C, 32'h0000_0000, "pend_cleared");

        // Edge event lands on the same edge that commits CLR.
        int_src = 16'hFFFB;
        tick(1);
        applyStimulus(1'b1, 20'h10, 32'h4, "clr_race");
        applyStimulus(1'b0, 20'h0C, 32'h0000_0004, "pend_race_kept");
        int_src = 16'hFFFF;
        tick(4);
        applyStimulus(1'b1, 20'h10, 32'h4, "clr_4b");

        // Software set on edge and level bits.
        applyStimulus(1'b1, 20'h04, 32'h6, "edge_6");
        applyStimulus(1'b1, 20'h00, 32'h2, "en_2");
        applyStimulus(1'b1, 20'h14, 32'h2, "set_2");
        tick(1);
        checkOutput("set_int_o", 0, 32'h1);
        checkOutput("set_int_id", 1, 32'h21);
        applyStimulus(1'b0, 20'h0C, 32'h0000_0002, "pend_set");
        applyStimulus(1'b1, 20'h14, 32'h8, "set_level");
        applyStimulus(1'b0, 20'h0C, 32'h0000_0002, "pend_set_level");
        applyStimulus(1'b0, 20'h18, 32'h8000_0001, "claim_src1");
        applyStimulus(1'b0, 20'h0C, 32'h0000_0000, "pend_after_claim");
        applyStimulus(1'b0, 20'h20, 32'h0000_0002, "insvc_2");

        // Reset asserted in the middle of a claim access.
        applyStimulus(1'b1, 20'h00, 32'h6, "en_6");
        applyStimulus(1'b1, 20'h14, 32'h4, "set_4");
        tick(1);
        checkOutput("pre_rst_int_o", 0, 32'h1);
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = 20'h18;
        tick(1);
        apb_penable = 1'b1;
        #1;
        apb_prstn = 1'b0;
        rdQ.push_back('{"claim_in_reset", 0, 32'h0});
        #1;
        checkOutput("async_rst_int_o", 0, 32'h0);
        checkOutput("async_rst_int_id", 1, 32'h0);
        tick(1);
        apb_psel = 1'b0; apb_penable = 1'b0;
        int_src = 16'h0000;
        tick(2);
        apb_prstn = 1'b1;
        tick(1);
        applyStimulus(1'b0, 20'h00, 32'h0000_0000, "post_rst_en");
        applyStimulus(1'b0, 20'h04, 32'h0000_0000, "post_rst_edge");
        applyStimulus(1'b0, 20'h08, 32'h0000_FFFF, "post_rst_pol");
        applyStimulus(1'b0, 20'h0C, 32'h0000_0000, "post_rst_pend");
        applyStimulus(1'b0, 20'h20, 32'h0000_0000, "post_rst_insvc");
        applyStimulus(1'b0, 20'h18, 32'h0000_0000, "post_rst_claim");
        checkOutput("post_rst_int_o", 0, 32'h0);

        tick(2);
        checks++;
        if (rdQ.size() != 0 || obsQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL queues_drained: got %0d/%0d pending, expected 0/0", rdQ.size(), obsQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
